// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: constant clog2, level-flag bundle and its derivation
// from an occupancy count.
package fifo_pkg;

    localparam logic FLAG_SET = 1'b1;
    localparam logic FLAG_CLR = 1'b0;

    typedef struct packed {
        logic full;
        logic empty;
        logic afull;
        logic aempty;
    } lvl_flags_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) width = i + 1;
        end
        return width;
    endfunction

    function automatic lvl_flags_t level_flags(input int unsigned cnt,
                                               input int unsigned depth,
                                               input int unsigned afull_thr,
                                               input int unsigned aempty_thr);
        lvl_flags_t f;
        f.full   = (cnt == depth);
        f.empty  = (cnt == 0);
        f.afull  = (cnt >= afull_thr);
        f.aempty = (cnt <= aempty_thr);
        return f;
    endfunction

endpackage

// File: rtl/sync_fifo_lvl_if.sv
// Push/pop/status bundle for sync_fifo_lvl; master drives requests, slave is the FIFO.
interface sync_fifo_lvl_if
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] i_wdata;
    logic             i_push;
    logic             i_pop;
    logic             i_flush;
    logic             i_err_clr;
    logic [WIDTH-1:0] o_rdata;
    logic             o_full;
    logic             o_not_full;
    logic             o_empty;
    logic             o_not_empty;
    logic             o_afull;
    logic             o_aempty;
    logic             o_overflow;
    logic             o_underflow;
    logic [CW-1:0]    o_count;

    modport master (
        output i_wdata, i_push, i_pop, i_flush, i_err_clr,
        input  o_rdata, o_full, o_not_full, o_empty, o_not_empty,
               o_afull, o_aempty, o_overflow, o_underflow, o_count
    );

    modport slave (
        input  i_wdata, i_push, i_pop, i_flush, i_err_clr,
        output o_rdata, o_full, o_not_full, o_empty, o_not_empty,
               o_afull, o_aempty, o_overflow, o_underflow, o_count
    );

endinterface

// File: rtl/fifo_wrap_ptr.sv
// Pointer counting 0..DEPTH-1 and wrapping, with synchronous clear.
module fifo_wrap_ptr
    import fifo_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned AW    = clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          inc,
    input  logic          clr,
    output logic [AW-1:0] ptr
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (inc) begin
            ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + AW'(1);
        end
    end

endmodule

// File: rtl/sync_fifo_lvl.sv
// Show-ahead synchronous FIFO with registered occupancy, level flags and
// sticky overflow/underflow indicators.
module sync_fifo_lvl
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AFULL_THR  = DEPTH - 1,
    parameter int unsigned AEMPTY_THR = 1
) (
    input logic           i_clk,
    input logic           i_rst_n,
    sync_fifo_lvl_if.slave bus
);

    localparam int unsigned AW = clog2(DEPTH);
    localparam int unsigned CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    lvl_flags_t       flags;
    logic             overflow;
    logic             underflow;
    logic             push_ok;
    logic             pop_ok;
    logic             wr_en;
    logic             rd_en;
    logic             ovf_set;
    logic             udf_set;

    // Flush wins over everything except error clearing; the error flags only
    // see push/pop conditions outside a flush cycle.
    always_comb begin
        push_ok = bus.i_push && (!flags.full || bus.i_pop);
        pop_ok  = bus.i_pop && !flags.empty;
        wr_en   = push_ok && !bus.i_flush;
        rd_en   = pop_ok && !bus.i_flush;
        ovf_set = !bus.i_flush && bus.i_push && flags.full && !bus.i_pop;
        udf_set = !bus.i_flush && bus.i_pop && flags.empty;
        if (bus.i_flush) count_nxt = '0;
        else             count_nxt = count + CW'(push_ok) - CW'(pop_ok);
    end

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wptr (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .inc    (wr_en),
        .clr    (bus.i_flush),
        .ptr    (wptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rptr (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .inc    (rd_en),
        .clr    (bus.i_flush),
        .ptr    (rptr)
    );

    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wptr] <= bus.i_wdata;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count     <= '0;
            flags     <= level_flags(0, DEPTH, AFULL_THR, AEMPTY_THR);
            overflow  <= FLAG_CLR;
            underflow <= FLAG_CLR;
        end else begin
            count <= count_nxt;
            flags <= level_flags(32'(count_nxt), DEPTH, AFULL_THR, AEMPTY_THR);
            if (ovf_set)            overflow <= FLAG_SET;
            else if (bus.i_err_clr) overflow <= FLAG_CLR;
            if (udf_set)            underflow <= FLAG_SET;
            else if (bus.i_err_clr) underflow <= FLAG_CLR;
        end
    end

    assign bus.o_rdata     = mem[rptr];
    assign bus.o_count     = count;
    assign bus.o_full      = flags.full;
    assign bus.o_not_full  = !flags.full;
    assign bus.o_empty     = flags.empty;
    assign bus.o_not_empty = !flags.empty;
    assign bus.o_afull     = flags.afull;
    assign bus.o_aempty    = flags.aempty;
    assign bus.o_overflow  = overflow;
    assign bus.o_underflow = underflow;

endmodule
